// File: rtl/time_sync_ctrl.sv
// Qualifies decoded radio-clock frames, loads the HH:MM:SS chain at the minute mark and forwards second ticks.
// Outputs are registered one cycle after the sampled mark/tick. No backpressure: every pulse is consumed in the cycle it arrives.
module time_sync_ctrl #(
    parameter int CONFIRM_FRAMES = 2,
    parameter int STALE_SECS     = 600
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sec_tick_i,
    input  logic        minute_mark_i,
    input  logic        frame_valid_i,
    input  logic [12:0] frame_time_i,
    output logic        load_o,
    output logic [19:0] load_value_o,
    output logic        inc_o,
    output logic        synced_o
);

    typedef enum logic [1:0] {HUNT, CONFIRM, ARMED, SYNCED} state_t;

    localparam int             SW        = $clog2(STALE_SECS + 1);
    localparam logic [SW-1:0]  STALE_MAX = SW'(STALE_SECS);
    localparam logic [2:0]     CONF_N    = 3'(CONFIRM_FRAMES);

    state_t        state, state_nxt, state_mid;
    logic [12:0]   last, last_nxt, expected;
    logic [2:0]    cnt, cnt_nxt;
    logic [SW-1:0] stale, stale_nxt;
    logic          pend, pend_nxt;
    logic          load_nxt, inc_nxt, synced_nxt;
    logic          accept, match;

    logic [1:0] f_ht;
    logic [3:0] f_hu;
    logic [2:0] f_mt;
    logic [3:0] f_mu;

    assign f_ht = frame_time_i[12:11];
    assign f_hu = frame_time_i[10:7];
    assign f_mt = frame_time_i[6:4];
    assign f_mu = frame_time_i[3:0];

    assign accept = frame_valid_i && (f_hu <= 4'd9) && (f_mu <= 4'd9) && (f_mt <= 3'd5)
                    && ((f_ht < 2'd2) || ((f_ht == 2'd2) && (f_hu <= 4'd3)));
    assign match  = (frame_time_i == expected);

    // BCD successor of the last accepted frame, wrapping 23:59 to 00:00.
    always_comb begin
        expected = last;
        if (last[3:0] != 4'd9) begin
            expected[3:0] = last[3:0] + 4'd1;
        end else begin
            expected[3:0] = 4'd0;
            if (last[6:4] != 3'd5) begin
                expected[6:4] = last[6:4] + 3'd1;
            end else begin
                expected[6:4] = 3'd0;
                if ((last[12:11] == 2'd2) && (last[10:7] == 4'd3)) begin
                    expected[12:7] = 6'd0;
                end else if (last[10:7] == 4'd9) begin
                    expected[10:7]  = 4'd0;
                    expected[12:11] = last[12:11] + 2'd1;
                end else begin
                    expected[10:7] = last[10:7] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= HUNT;
        else         state <= state_nxt;
    end

    // The mark acts first on the held state; the frame is then judged in the post-mark state.
    assign state_mid = load_nxt ? SYNCED : state;

    always_comb begin
        state_nxt = state_mid;
        last_nxt  = last;
        cnt_nxt   = cnt;
        pend_nxt  = load_nxt ? 1'b0 : pend;
        stale_nxt = stale;
        if ((state == SYNCED) && sec_tick_i && (stale != STALE_MAX))
            stale_nxt = stale + 1'b1;
        if (accept) begin
            last_nxt = frame_time_i;
            unique case (state_mid)
                HUNT: begin
                    cnt_nxt   = 3'd1;
                    state_nxt = CONFIRM;
                end
                CONFIRM: begin
                    if (match) begin
                        cnt_nxt = cnt + 3'd1;
                        if (cnt_nxt >= CONF_N) state_nxt = ARMED;
                    end else begin
                        cnt_nxt = 3'd1;
                    end
                end
                ARMED: begin
                    if (!match) begin
                        cnt_nxt   = 3'd1;
                        state_nxt = CONFIRM;
                    end
                end
                SYNCED: begin
                    pend_nxt = match;
                    if (match) stale_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        load_nxt   = minute_mark_i && ((state == ARMED) || ((state == SYNCED) && pend));
        inc_nxt    = sec_tick_i && (state == SYNCED) && !load_nxt;
        synced_nxt = synced_o;
        if (load_nxt)                     synced_nxt = 1'b1;
        else if (stale_nxt == STALE_MAX)  synced_nxt = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last         <= '0;
            cnt          <= '0;
            pend         <= 1'b0;
            stale        <= '0;
            load_o       <= 1'b0;
            load_value_o <= '0;
            inc_o        <= 1'b0;
            synced_o     <= 1'b0;
        end else begin
            last     <= last_nxt;
            cnt      <= cnt_nxt;
            pend     <= pend_nxt;
            stale    <= stale_nxt;
            load_o   <= load_nxt;
            inc_o    <= inc_nxt;
            synced_o <= synced_nxt;
            if (load_nxt) load_value_o <= {last, 7'b0};
        end
    end

endmodule

// File: tb/tb_time_sync_ctrl.sv
// Bench for time_sync_ctrl: vector table, multi-cycle corner sequences, then random traffic against a minute-count model.
module tb_time_sync_ctrl;

    localparam int CF = 2;
    localparam int ST = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        mark = 1'b0;
    logic        fv = 1'b0;
    logic [12:0] ft = '0;
    logic        load;
    logic [19:0] load_val;
    logic        inc;
    logic        synced;

    always #5 clk = ~clk;

    time_sync_ctrl #(.CONFIRM_FRAMES(CF), .STALE_SECS(ST)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .sec_tick_i    (tick),
        .minute_mark_i (mark),
        .frame_valid_i (fv),
        .frame_time_i  (ft),
        .load_o        (load),
        .load_value_o  (load_val),
        .inc_o         (inc),
        .synced_o      (synced)
    );

    typedef struct {
        bit          rst;
        bit          mk;
        bit          tk;
        bit          v;
        logic [12:0] f;
        bit          e_load;
        logic [19:0] e_val;
        bit          e_inc;
        bit          e_sync;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [12:0] hm(int h, int m);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic [19:0] lv(int h, int m);
        return {hm(h, m), 7'b0};
    endfunction

    function automatic vec_t mkv(bit r, bit mk, bit tk, bit v, logic [12:0] f,
                                 bit el, logic [19:0] ev, bit ei, bit es);
        vec_t x;
        x.rst = r; x.mk = mk; x.tk = tk; x.v = v; x.f = f;
        x.e_load = el; x.e_val = ev; x.e_inc = ei; x.e_sync = es;
        return x;
    endfunction

    task automatic check1(string tag, int idx, string what, logic [19:0] got, logic [19:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s[%0d] %s got %0h want %0h", tag, idx, what, got, want);
        end
    endtask

    task automatic drive(bit r, bit mk, bit tk, bit v, logic [12:0] f);
        rst_n = !r; mark = mk; tick = tk; fv = v; ft = f;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(string tag, int idx, vec_t x);
        drive(x.rst, x.mk, x.tk, x.v, x.f);
        check1(tag, idx, "load",   {19'b0, load},   {19'b0, x.e_load});
        check1(tag, idx, "value",  load_val,        x.e_val);
        check1(tag, idx, "inc",    {19'b0, inc},    {19'b0, x.e_inc});
        check1(tag, idx, "synced", {19'b0, synced}, {19'b0, x.e_sync});
    endtask

    // Reference model: time kept as minute-of-day, progress as a streak of consecutive matches.
    int          m_last, m_streak, m_stale;
    bit          m_have, m_loaded, m_pend, m_sync, m_load, m_inc;
    logic [19:0] m_val;

    function automatic int to_min(logic [12:0] f);
        int h, m;
        if (f[10:7] > 4'd9 || f[3:0] > 4'd9) return -1;
        h = int'(f[12:11]) * 10 + int'(f[10:7]);
        m = int'(f[6:4]) * 10 + int'(f[3:0]);
        if (h > 23 || m > 59) return -1;
        return h * 60 + m;
    endfunction

    function automatic logic [12:0] enc(int mins);
        return hm(mins / 60, mins % 60);
    endfunction

    task automatic model_reset();
        m_last = 0; m_streak = 0; m_stale = 0;
        m_have = 0; m_loaded = 0; m_pend = 0; m_sync = 0; m_load = 0; m_inc = 0;
        m_val = '0;
    endtask

    task automatic model_step(bit mk, bit tk, bit v, logic [12:0] f);
        bit was_loaded;
        bit hit;
        int fm;
        was_loaded = m_loaded;
        m_load = mk && ((!m_loaded && m_have && m_streak >= CF) || (m_loaded && m_pend));
        if (m_load) begin
            m_val = {enc(m_last), 7'b0};
            m_loaded = 1;
            m_pend = 0;
        end
        m_inc = tk && was_loaded && !m_load;
        if (was_loaded && tk && m_stale < ST) m_stale++;
        fm = v ? to_min(f) : -1;
        if (fm >= 0) begin
            hit = m_have && (fm == (m_last + 1) % 1440);
            if (m_loaded) begin
                m_pend = hit;
                if (hit) m_stale = 0;
            end else begin
                m_streak = hit ? m_streak + 1 : 1;
            end
            m_last = fm;
            m_have = 1;
        end
        if (m_load) m_sync = 1;
        else if (m_stale >= ST) m_sync = 0;
    endtask

    vec_t tbl[34];

    initial begin
        logic [19:0] Z;
        Z = '0;
        tbl[0]  = mkv(1,0,0,0,13'd0,       0,Z,0,0);
        tbl[1]  = mkv(0,0,0,1,hm(12,34),   0,Z,0,0);
        tbl[2]  = mkv(0,1,0,0,13'd0,       0,Z,0,0);
        tbl[3]  = mkv(0,0,0,1,hm(12,35),   0,Z,0,0);
        tbl[4]  = mkv(0,0,1,0,13'd0,       0,Z,0,0);
        tbl[5]  = mkv(0,1,1,0,13'd0,       1,lv(12,35),0,1);
        tbl[6]  = mkv(0,0,1,0,13'd0,       0,lv(12,35),1,1);
        tbl[7]  = mkv(0,0,0,1,hm(12,36),   0,lv(12,35),0,1);
        tbl[8]  = mkv(0,1,0,0,13'd0,       1,lv(12,36),0,1);
        tbl[9]  = mkv(0,0,0,1,hm(24,0),    0,lv(12,36),0,1);
        tbl[10] = mkv(0,0,0,1,hm(12,60),   0,lv(12,36),0,1);
        tbl[11] = mkv(0,0,0,1,hm(12,37),   0,lv(12,36),0,1);
        tbl[12] = mkv(0,1,0,0,13'd0,       1,lv(12,37),0,1);
        tbl[13] = mkv(1,0,0,0,13'd0,       0,Z,0,0);
        tbl[14] = mkv(0,0,0,1,hm(23,59),   0,Z,0,0);
        tbl[15] = mkv(0,0,0,1,hm(0,0),     0,Z,0,0);
        tbl[16] = mkv(0,1,0,0,13'd0,       1,lv(0,0),0,1);
        tbl[17] = mkv(1,0,0,0,13'd0,       0,Z,0,0);
        tbl[18] = mkv(0,0,0,1,hm(9,59),    0,Z,0,0);
        tbl[19] = mkv(0,0,0,1,hm(10,0),    0,Z,0,0);
        tbl[20] = mkv(0,1,0,0,13'd0,       1,lv(10,0),0,1);
        tbl[21] = mkv(1,0,0,0,13'd0,       0,Z,0,0);
        tbl[22] = mkv(0,0,0,1,hm(12,34),   0,Z,0,0);
        tbl[23] = mkv(0,0,0,1,hm(12,36),   0,Z,0,0);
        tbl[24] = mkv(0,1,0,0,13'd0,       0,Z,0,0);
        tbl[25] = mkv(0,0,0,1,hm(12,37),   0,Z,0,0);
        tbl[26] = mkv(0,1,0,0,13'd0,       1,lv(12,37),0,1);
        tbl[27] = mkv(1,0,0,0,13'd0,       0,Z,0,0);
        tbl[28] = mkv(0,0,0,1,hm(24,0),    0,Z,0,0);
        tbl[29] = mkv(0,0,0,1,hm(12,35),   0,Z,0,0);
        tbl[30] = mkv(0,0,0,1,hm(12,60),   0,Z,0,0);
        tbl[31] = mkv(0,0,0,1,hm(12,36),   0,Z,0,0);
        tbl[32] = mkv(0,0,0,1,hm(24,0),    0,Z,0,0);
        tbl[33] = mkv(0,1,0,0,13'd0,       1,lv(12,36),0,1);

        #2;
        check1("reset", 0, "load",   {19'b0, load},   20'd0);
        check1("reset", 0, "value",  load_val,        20'd0);
        check1("reset", 0, "inc",    {19'b0, inc},    20'd0);
        check1("reset", 0, "synced", {19'b0, synced}, 20'd0);

        for (int i = 0; i < 34; i++) apply("tbl", i, tbl[i]);

        // Stale timeout: synced drops after ST ticks, inc keeps running, matching frame + mark restores it.
        apply("stale", 0, mkv(1,0,0,0,13'd0,     0,Z,0,0));
        apply("stale", 1, mkv(0,0,0,1,hm(8,0),   0,Z,0,0));
        apply("stale", 2, mkv(0,0,0,1,hm(8,1),   0,Z,0,0));
        apply("stale", 3, mkv(0,1,0,0,13'd0,     1,lv(8,1),0,1));
        for (int i = 1; i <= ST + 1; i++)
            apply("stale", 3 + i, mkv(0,0,1,0,13'd0, 0,lv(8,1),1,(i < ST)));
        apply("stale", 10, mkv(0,0,0,1,hm(8,2),  0,lv(8,1),0,0));
        apply("stale", 11, mkv(0,1,0,0,13'd0,    1,lv(8,2),0,1));

        // Reset while armed cancels the pending load; next frame restarts the hunt.
        apply("rstarm", 0, mkv(1,0,0,0,13'd0,    0,Z,0,0));
        apply("rstarm", 1, mkv(0,0,0,1,hm(12,34),0,Z,0,0));
        apply("rstarm", 2, mkv(0,0,0,1,hm(12,35),0,Z,0,0));
        apply("rstarm", 3, mkv(1,0,0,0,13'd0,    0,Z,0,0));
        apply("rstarm", 4, mkv(0,1,1,0,13'd0,    0,Z,0,0));
        apply("rstarm", 5, mkv(0,0,1,1,hm(12,36),0,Z,0,0));
        apply("rstarm", 6, mkv(0,1,0,0,13'd0,    0,Z,0,0));
        apply("rstarm", 7, mkv(0,0,0,1,hm(12,37),0,Z,0,0));
        apply("rstarm", 8, mkv(0,1,0,0,13'd0,    1,lv(12,37),0,1));

        // Mark, tick and frame in the same cycle, then reload with a coincident tick.
        apply("simul", 0, mkv(1,0,0,0,13'd0,     0,Z,0,0));
        apply("simul", 1, mkv(0,0,0,1,hm(12,35), 0,Z,0,0));
        apply("simul", 2, mkv(0,0,0,1,hm(12,36), 0,Z,0,0));
        apply("simul", 3, mkv(0,1,1,1,hm(12,37), 1,lv(12,36),0,1));
        apply("simul", 4, mkv(0,0,1,0,13'd0,     0,lv(12,36),1,1));
        apply("simul", 5, mkv(0,1,1,0,13'd0,     1,lv(12,37),0,1));
        apply("simul", 6, mkv(0,1,1,0,13'd0,     0,lv(12,37),1,1));
        apply("simul", 7, mkv(0,0,0,1,hm(3,0),   0,lv(12,37),0,1));
        apply("simul", 8, mkv(0,1,0,0,13'd0,     0,lv(12,37),0,1));
        apply("simul", 9, mkv(0,0,0,1,hm(3,1),   0,lv(12,37),0,1));
        apply("simul", 10, mkv(0,1,0,0,13'd0,    1,lv(3,1),0,1));

        // Random traffic against the model.
        drive(1, 0, 0, 0, 13'd0);
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            bit          r, mk, tk, v;
            logic [12:0] f;
            int          sel;
            r   = ($urandom_range(0, 499) == 0);
            mk  = ($urandom_range(0, 9) == 0);
            tk  = ($urandom_range(0, 2) == 0);
            v   = ($urandom_range(0, 4) == 0);
            sel = int'($urandom_range(0, 9));
            if (sel < 6 && m_have) f = enc((m_last + 1) % 1440);
            else if (sel < 8)      f = enc(int'($urandom_range(0, 1439)));
            else                   f = 13'($urandom);
            drive(r, mk, tk, v, f);
            if (r) model_reset();
            else   model_step(mk, tk, v, f);
            check1("rnd", c, "load",   {19'b0, load},   {19'b0, m_load});
            check1("rnd", c, "value",  load_val,        m_val);
            check1("rnd", c, "inc",    {19'b0, inc},    {19'b0, m_inc});
            check1("rnd", c, "synced", {19'b0, synced}, {19'b0, m_sync});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/time_sync_ctrl.md
TIME_SYNC_CTRL -- requirements
Module: time_sync_ctrl

Interface
REQ-001 SHALL have parameter CONFIRM_FRAMES, default 2, meaning consecutive consistent frames needed before the first load (range 2..7).
REQ-002 SHALL have parameter STALE_SECS, default 600, meaning seconds without an accepted frame before synced_o drops.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port sec_tick_i, input, 1, one-cycle pulse per second.
REQ-006 SHALL have port minute_mark_i, input, 1, one-cycle pulse at the start of each minute (second 00).
REQ-007 SHALL have port frame_valid_i, input, 1, one-cycle pulse: frame_time_i holds a parity-checked decoded time.
REQ-008 SHALL have port frame_time_i, input, 13, BCD HH:MM of the minute starting at the next mark: [12:11] hour tens, [10:7] hour units, [6:4] min tens, [3:0] min units.
REQ-009 SHALL have port load_o, input to the HH:MM:SS digit chain, output, 1, one-cycle load strobe.
REQ-010 SHALL have port load_value_o, output, 20, chain load word: [19:18] hour tens, [17:14] hour units, [13:11] min tens, [10:7] min units, [6:4] sec tens, [3:0] sec units; seconds fields always 0.
REQ-011 SHALL have port inc_o, output, 1, one-cycle increment pulse to the seconds-units digit.
REQ-012 SHALL have port synced_o, output, 1, high while displayed time is backed by a recent accepted frame.

Function
REQ-013 Frame SHALL be accepted only if hour <= 23, hour units <= 9, minutes <= 59, minute units <= 9; rejected frames SHALL leave all state unchanged.
REQ-014 Block SHALL hold expected = last accepted frame + 1 minute in BCD: min units 9->0 carries to tens; min 59->00 carries to hour; hour units 9->0 carries; 23:59 -> 00:00.
REQ-015 States: HUNT, CONFIRM, ARMED, SYNCED.
REQ-016 HUNT: accepted frame -> store as last, match count = 1, go CONFIRM.
REQ-017 CONFIRM: accepted frame equal to expected -> count+1, store; count reaching CONFIRM_FRAMES -> ARMED. Accepted frame not equal -> store as last, count = 1, stay CONFIRM.
REQ-018 ARMED: minute_mark_i -> load_o pulse with load_value_o = {last frame, 7'b0}, go SYNCED; accepted frame equal to expected -> store, stay ARMED; unequal -> store, count = 1, go CONFIRM.
REQ-019 SYNCED: accepted frame equal to expected -> store, stale counter cleared, reload at next minute_mark_i; unequal -> store as last, no reload until a following frame matches; clock keeps free-running.
REQ-020 load_o SHALL assert exactly one cycle, the cycle after minute_mark_i is sampled; load_value_o SHALL be registered and stable that cycle.
REQ-021 inc_o SHALL equal sec_tick_i delayed one cycle, except forced 0 in any cycle where load_o is 1 (mark second is set by load, not counted).
REQ-022 inc_o SHALL be 0 in HUNT, CONFIRM and ARMED (chain not yet set).
REQ-023 Stale counter SHALL count sec_tick_i in SYNCED, saturate at STALE_SECS, clear on accepted matching frame; at STALE_SECS synced_o SHALL drop while state stays SYNCED and inc_o continues.
REQ-024 synced_o SHALL be 1 from the load_o cycle entering SYNCED until stale saturation; after stale, the next matching frame SHALL raise synced_o at its reload.
REQ-025 Simultaneous frame_valid_i and minute_mark_i: mark SHALL act on the state and last frame as held before that cycle; frame SHALL then be evaluated normally.
REQ-026 Simultaneous sec_tick_i and minute_mark_i in SYNCED with reload pending: load_o wins, inc_o suppressed.

Reset
REQ-027 rst_ni low SHALL asynchronously force state HUNT, load_o 0, load_value_o 0, inc_o 0, synced_o 0, match count 0, stale counter 0, last frame 0.
REQ-028 Reset deassertion SHALL be honoured synchronously; first frame after reset is treated as the HUNT frame; a reset mid-ARMED SHALL suppress the pending load.

Verification
REQ-029 Frames 12:34, 12:35 (default parameters), then mark -> load_o one cycle after mark, load_value_o = 12:35:00, synced_o 1, inc_o 0 that cycle.
REQ-030 Frames 23:59, 00:00, mark -> load 00:00:00; frames 09:59, 10:00 -> load 10:00:00.
REQ-031 Frames 12:34, 12:36, 12:37, mark -> load 12:37:00 only after third frame; mark after second frame -> no load_o.
REQ-032 Frame 24:00 or 12:60 in any state -> no state, count, or output change.
REQ-033 SYNCED, STALE_SECS=5, no frames, 5 sec_tick_i -> synced_o 0, inc_o still pulses; next matching frame + mark -> reload, synced_o 1.
REQ-034 rst_ni low while ARMED, released before mark -> no load_o, state HUNT, all outputs 0.
